uart_tx_serializer: RTL
=======================

Name: uart_tx_serializer

Overview:
- UART transmit serializer that sits directly downstream of the counters/divider stage.
- Consumes a one-clock-wide baud enable pulse (baud_tick), produced by the divider from clk_in, and shifts out a framed byte on txd.
- Frame order: start bit, data bits LSB first, optional parity bit, one or two stop bits.
- Byte intake uses a valid/ready handshake from the upstream byte source.

Parameters:
- DATA_BITS, 8, data bits per frame; legal values 5..8.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, selects parity sense when PARITY_EN=1: 0 = even, 1 = odd.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk_in, input, 1, single system clock; all state updates on posedge.
- reset, input, 1, asynchronous active-low reset; 0 resets immediately, independent of clk_in.
- baud_tick, input, 1, one-clk_in-cycle enable pulse, one per bit period.
- tx_data, input, DATA_BITS, byte to send; sampled only on handshake.
- tx_valid, input, 1, upstream has a byte on tx_data.
- tx_ready, output, 1, block can accept a byte; high only in IDLE.
- txd, output, 1, serial line; idle level 1.
- busy, output, 1, high from handshake until the last stop bit period ends.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, txd=1, tx_ready=1, busy=0.
  - Shift register and counters cleared.
  - A reset asserted mid-frame aborts the frame; txd returns to 1 immediately, with no glitch low.
- Handshake:
  - Transfer occurs on a posedge where tx_valid=1 and tx_ready=1.
  - On that edge: tx_data is latched into the shift register, parity is computed and latched, and state goes to SYNC.
  - tx_ready drops and busy rises on the same edge.
  - tx_data is don't-care outside the handshake.
- States:
  - IDLE: txd=1. Go to SYNC on handshake. baud_tick is ignored.
  - SYNC: txd=1. On the first edge with baud_tick=1, set txd<=0 and go to START. A tick coincident with the handshake edge is not counted; SYNC always waits for a later tick.
  - START: on a baud_tick edge, set txd<=shift[0], shift right, bit_cnt<=0, go to DATA.
  - DATA: on a baud_tick edge:
    - If bit_cnt==DATA_BITS-1: go to PARITY with txd<=parity when PARITY_EN=1, else go to STOP with txd<=1 and stop_cnt<=0.
    - Otherwise: set txd<=shift[0], shift, bit_cnt<=bit_cnt+1.
  - PARITY: on a baud_tick edge, set txd<=1, stop_cnt<=0, go to STOP.
  - STOP: on a baud_tick edge:
    - If stop_cnt==STOP_BITS-1: go to IDLE, tx_ready<=1, busy<=0.
    - Otherwise: stop_cnt<=stop_cnt+1.
- Timing:
  - Each bit is held on txd for exactly one baud_tick interval. Bit transitions are aligned to the clk_in edge that samples baud_tick=1.
  - Latency from handshake to the txd falling edge is the time to the next baud_tick, at least 1 clk_in cycle.
  - Frame length in ticks is 1 + DATA_BITS + PARITY_EN + STOP_BITS.
- Parity: XOR of the DATA_BITS data bits. Even parity outputs the XOR; odd parity outputs its inverse.
- Back-to-back frames:
  - tx_ready rises on the edge that ends the last stop bit.
  - If tx_valid is already high, the handshake occurs on the next edge.
  - The next start bit begins on the following baud_tick, so there is one full idle-high tick period minimum between frames.
- Invariants:
  - baud_tick held high continuously advances one bit per clk_in cycle.
  - tx_valid deasserting while tx_ready=0 has no effect.
  - No byte is accepted while busy=1.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release -> txd=1, tx_ready=1, busy=0. Assert reset=0 mid-DATA -> txd=1 the same cycle, no posedge needed.
- 8N1, baud_tick every 5 clk_in cycles (divide-by-5 source), send 0xA5:
  - txd per tick = 0,1,0,1,0,0,1,0,1,1.
  - busy high for 10 ticks plus SYNC wait.
  - tx_ready returns on the end of the stop bit.
- PARITY_EN=1, send 0xA5 (four ones):
  - PARITY_ODD=0 -> parity bit 0.
  - PARITY_ODD=1 -> parity bit 1.
  - Frame length 11 ticks.
- STOP_BITS=2, DATA_BITS=5, send 0x13 -> txd = 0,1,1,0,0,1,1,1; tx_ready low throughout.
- Back-to-back: tx_valid held high with 0x00 then 0xFF -> two frames, with exactly one idle-high tick between the last stop bit and the second start bit. No byte is dropped or duplicated.
- Handshake on the same edge as baud_tick=1 -> start bit begins on the next tick, not the coincident one. tx_valid pulsed while busy -> ignored, txd unchanged.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: frames a byte (start, data LSB first, optional parity,
// 1..2 stop bits) and shifts it out on txd, one bit per baud_tick.
`timescale 1ns/1ps

module uart_tx_serializer #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  state_t               state_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_next;
  logic                 parity_reg;
  logic                 parity_next;
  logic [2:0]           bit_cnt_reg;
  logic                 stop_cnt_reg;
  logic                 txd_reg;
  logic                 tx_ready_reg;
  logic                 busy_reg;

  // Odd parity is the inverted XOR; folding the sense in here keeps the FSM uniform.
  always_comb begin
    parity_next = 1'(PARITY_ODD);
    for (int i = 0; i < int'(DATA_BITS); i++) begin
      parity_next = parity_next ^ tx_data[i];
    end
  end

  assign shift_next = {1'b0, shift_reg[DATA_BITS-1:1]};

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      txd_reg      <= 1'b1;
      tx_ready_reg <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          txd_reg <= 1'b1;
          if (tx_valid && tx_ready_reg) begin
            shift_reg    <= tx_data;
            parity_reg   <= parity_next;
            tx_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= SYNC;
          end
        end

        // A tick on the handshake edge was seen in IDLE, so SYNC always waits for a later one.
        SYNC: begin
          if (baud_tick) begin
            txd_reg   <= 1'b0;
            state_reg <= START;
          end
        end

        START: begin
          if (baud_tick) begin
            txd_reg     <= shift_reg[0];
            shift_reg   <= shift_next;
            bit_cnt_reg <= '0;
            state_reg   <= DATA;
          end
        end

        DATA: begin
          if (baud_tick) begin
            if (bit_cnt_reg == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                txd_reg   <= parity_reg;
                state_reg <= PARITY;
              end else begin
                txd_reg      <= 1'b1;
                stop_cnt_reg <= 1'b0;
                state_reg    <= STOP;
              end
            end else begin
              txd_reg     <= shift_reg[0];
              shift_reg   <= shift_next;
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
          end
        end

        PARITY: begin
          if (baud_tick) begin
            txd_reg      <= 1'b1;
            stop_cnt_reg <= 1'b0;
            state_reg    <= STOP;
          end
        end

        STOP: begin
          if (baud_tick) begin
            if (stop_cnt_reg == LAST_STOP) begin
              tx_ready_reg <= 1'b1;
              busy_reg     <= 1'b0;
              state_reg    <= IDLE;
            end else begin
              stop_cnt_reg <= stop_cnt_reg + 1'b1;
            end
          end
        end

        default: begin
          txd_reg      <= 1'b1;
          tx_ready_reg <= 1'b1;
          busy_reg     <= 1'b0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

  assign txd      = txd_reg;
  assign tx_ready = tx_ready_reg;
  assign busy     = busy_reg;

endmodule
